bcd_updown_counter: RTL and testbench

//   Parametrised N-digit cascaded BCD counter with up/down direction and synchronous preset load.

---
 rtl/bcd_pkg.sv | 14 +
 rtl/bcd_digit.sv | 43 ++++
 rtl/bcd_updown_counter.sv | 73 +++++++
 tb/tb_bcd_updown_counter.sv | 140 ++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// Shared BCD digit type, digit limits and the preset clamp used by the BCD up/down counter.
package bcd_pkg;

  typedef logic [3:0] bcd_digit_t;

  localparam bcd_digit_t BCD_MAX = 4'd9;
  localparam bcd_digit_t BCD_MIN = 4'd0;

  // Forces an out-of-range nibble (A..F) to the largest legal digit.
  function automatic bcd_digit_t bcd_clamp(input bcd_digit_t d);
    return (d > BCD_MAX) ? BCD_MAX : d;
  endfunction

endpackage

// File: rtl/bcd_digit.sv
// One BCD digit register: synchronous reset, clamped preset load, and wrap-around up/down step when enabled.
module bcd_digit
  import bcd_pkg::*;
(
  input  logic       clk,
  input  logic       srst,
  input  logic       en,
  input  logic       up,
  input  logic       load,
  input  bcd_digit_t d,
  output bcd_digit_t val,
  output logic       tc
);

  bcd_digit_t val_reg;
  bcd_digit_t val_next;

  always_comb begin
    val_next = val_reg;
    if (load) begin
      val_next = bcd_clamp(d);
    end else if (en) begin
      if (up) begin
        val_next = (val_reg == BCD_MAX) ? BCD_MIN : val_reg + 4'd1;
      end else begin
        val_next = (val_reg == BCD_MIN) ? BCD_MAX : val_reg - 4'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      val_reg <= BCD_MIN;
    end else begin
      val_reg <= val_next;
    end
  end

  assign val = val_reg;
  // Terminal count in the current direction: this digit will roll over on the next step.
  assign tc  = up ? (val_reg == BCD_MAX) : (val_reg == BCD_MIN);

endmodule

// File: rtl/bcd_updown_counter.sv
// N-digit cascaded BCD up/down counter with clamped preset load.
// Define BCD_SATURATE_EN to hold at 9..9 / 0..0 instead of wrapping.
module bcd_updown_counter
  import bcd_pkg::*;
#(
  parameter int DIGITS = 3
) (
  input  logic                Clk,
  input  logic                Rst,
  input  logic                Cin,
  input  logic                Up,
  input  logic                Load,
  input  logic [4*DIGITS-1:0] Din,
  output logic [4*DIGITS-1:0] q,
  output logic                Cout,
  output logic                Load_err
);

  logic [DIGITS-1:0] tc;
  logic [DIGITS-1:0] en;
  logic [DIGITS-1:0] nib_bad;
  logic              all_tc;
  logic              cin_eff;
  logic              load_err_reg;

  assign all_tc = &tc;

`ifdef BCD_SATURATE_EN
  // At the terminal value the whole counter freezes rather than wrapping.
  assign cin_eff = Cin & ~all_tc;
`else
  assign cin_eff = Cin;
`endif

  genvar gi;
  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_digit
      if (gi == 0) begin : g_first
        assign en[gi] = cin_eff;
      end else begin : g_rest
        assign en[gi] = en[gi-1] & tc[gi-1];
      end

      assign nib_bad[gi] = (Din[4*gi +: 4] > BCD_MAX);

      bcd_digit u_digit (
        .clk  (Clk),
        .srst (Rst),
        .en   (en[gi]),
        .up   (Up),
        .load (Load),
        .d    (Din[4*gi +: 4]),
        .val  (q[4*gi +: 4]),
        .tc   (tc[gi])
      );
    end
  endgenerate

  // Error flag lives only for the cycle after the offending load.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      load_err_reg <= 1'b0;
    end else if (Load) begin
      load_err_reg <= |nib_bad;
    end else begin
      load_err_reg <= 1'b0;
    end
  end

  assign Load_err = load_err_reg;
  assign Cout     = Cin & ~Load & ~Rst & all_tc;

endmodule

// File: tb/tb_bcd_updown_counter.sv
// Randomized plus directed check of bcd_updown_counter (DIGITS=3) against an integer-valued reference model.
module tb_bcd_updown_counter;

  localparam int DIGITS = 3;
  localparam int MODV   = 1000;

  logic                Clk = 1'b0;
  logic                Rst = 1'b1;
  logic                Cin = 1'b0;
  logic                Up = 1'b1;
  logic                Load = 1'b0;
  logic [4*DIGITS-1:0] Din = '0;
  logic [4*DIGITS-1:0] q;
  logic                Cout;
  logic                Load_err;

  int mv   = 0;
  int merr = 0;
  int total = 0;
  int bad   = 0;

  bcd_updown_counter #(.DIGITS(DIGITS)) dut (
    .Clk      (Clk),
    .Rst      (Rst),
    .Cin      (Cin),
    .Up       (Up),
    .Load     (Load),
    .Din      (Din),
    .q        (q),
    .Cout     (Cout),
    .Load_err (Load_err)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h (model value %0d)", tag, got, exp, mv);
    end
  endtask

  function automatic logic [11:0] to_bcd(input int v);
    return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  function automatic int preset_value(input logic [11:0] d);
    int r = 0;
    int w = 1;
    for (int k = 0; k < DIGITS; k++) begin
      int n = int'(d[4*k +: 4]);
      if (n > 9) n = 9;
      r += n * w;
      w *= 10;
    end
    return r;
  endfunction

  function automatic int preset_bad(input logic [11:0] d);
    for (int k = 0; k < DIGITS; k++)
      if (d[4*k +: 4] > 4'd9) return 1;
    return 0;
  endfunction

  // Drive one cycle, check pre-edge outputs against the model, then advance the model.
  task automatic step(input logic r, input logic l, input logic c, input logic u, input logic [11:0] d);
    logic exp_cout;
    Rst = r; Load = l; Cin = c; Up = u; Din = d;
    #1;
    exp_cout = c & ~l & ~r & (u ? (mv == MODV - 1) : (mv == 0));
    check("q", 32'(q), 32'(to_bcd(mv)));
    check("load_err", 32'(Load_err), 32'(merr));
    check("cout", 32'(Cout), 32'(exp_cout));
    @(posedge Clk);
    if (r) begin
      mv = 0; merr = 0;
    end else if (l) begin
      mv = preset_value(d); merr = preset_bad(d);
    end else begin
      merr = 0;
      if (c) begin
`ifdef BCD_SATURATE_EN
        if (u) mv = (mv == MODV - 1) ? mv : mv + 1;
        else   mv = (mv == 0) ? 0 : mv - 1;
`else
        if (u) mv = (mv + 1) % MODV;
        else   mv = (mv + MODV - 1) % MODV;
`endif
      end
    end
    @(negedge Clk);
  endtask

  initial begin
    // Unchecked first reset edge: q is unknown before it.
    Rst = 1'b1;
    @(posedge Clk);
    @(negedge Clk);
    mv = 0; merr = 0;

    for (int i = 0; i < 200; i++) step(1'b1, 1'b1, 1'b1, 1'($urandom), 12'($urandom));
    for (int i = 0; i < 1001; i++) step(1'b0, 1'b0, 1'b1, 1'b1, 12'h000);

    step(1'b0, 1'b1, 1'b0, 1'b1, 12'h010);
    for (int i = 0; i < 12; i++) step(1'b0, 1'b0, 1'b1, 1'b0, 12'h000);

    step(1'b0, 1'b1, 1'b0, 1'b1, 12'h1A5);
    step(1'b0, 1'b0, 1'b0, 1'b1, 12'h000);
    step(1'b0, 1'b1, 1'b0, 1'b1, 12'h123);
    step(1'b0, 1'b1, 1'b0, 1'b1, 12'hFFF);
    step(1'b0, 1'b0, 1'b0, 1'b0, 12'h000);

    step(1'b0, 1'b1, 1'b0, 1'b1, 12'h456);
    step(1'b0, 1'b1, 1'b1, 1'b1, 12'h100);
    step(1'b1, 1'b1, 1'b1, 1'b1, 12'h789);
    step(1'b0, 1'b0, 1'b0, 1'b1, 12'h000);

    step(1'b0, 1'b1, 1'b0, 1'b1, 12'h998);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b1, 1'b1, 12'h000);
    step(1'b0, 1'b0, 1'b1, 1'b0, 12'h000);
    step(1'b0, 1'b1, 1'b0, 1'b0, 12'h001);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b1, 1'b0, 12'h000);

    for (int i = 0; i < 3000; i++) begin
      logic r, l;
      logic [11:0] d;
      r = ($urandom_range(0, 99) < 2);
      l = ($urandom_range(0, 99) < 6);
      d = 12'($urandom);
      if ($urandom_range(0, 3) != 0) d = to_bcd($urandom_range(0, MODV - 1));
      if ($urandom_range(0, 7) == 0) d = ($urandom_range(0, 1) != 0) ? 12'h999 : 12'h000;
      step(r, l, 1'($urandom_range(0, 3) != 0), 1'($urandom), d);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
